psum_writeback: RTL and testbench

- Output stage directly downstream of the 3x3 PE (pe1).
- Takes the PE's signed partial sums and accumulates them across input-channel groups.
- Applies ReLU, a right shift and saturation to int8 on each finished sum, then packs 8 results into one 64-bit word.
- Writes each packed word through one write port of a BRAM4k-style feature buffer (12-bit address, 64-bit data), ready for the next conv layer.

---
 rtl/psum_writeback_if.sv | 32 +++
 rtl/psum_writeback.sv | 173 +++++++++++++++++
 tb/tb_psum_writeback.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_writeback_if.sv
// Port bundle for the partial-sum writeback stage.
// Carries the PE partial-sum stream (valid/ready handshake) and the
// single-port BRAM write bus. The master side is the surrounding fabric
// (PE upstream, BRAM downstream); the slave side is the writeback stage.
interface psum_writeback_if #(
   parameter int PSUM_W = 20,
   parameter int ADDR_W = 12,
   parameter int LANES  = 8
);
   // Partial-sum stream from the PE
   logic                  psum_valid;
   logic [PSUM_W-1:0]     psum_data;
   logic                  psum_last;
   logic                  psum_ready;

   // Feature-buffer write port (wea/addra/dina)
   logic                  bram_we;
   logic [ADDR_W-1:0]     bram_addr;
   logic [8*LANES-1:0]    bram_din;

   modport master (
      output psum_valid, psum_data, psum_last,
      input  psum_ready,
      input  bram_we, bram_addr, bram_din
   );

   modport slave (
      input  psum_valid, psum_data, psum_last,
      output psum_ready,
      output bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/psum_writeback.sv
// Output stage behind the 3x3 PE: accumulates signed partial sums across
// input-channel groups, applies ReLU / requant shift / int8 clamp to each
// finished sum, packs LANES results per word and writes each full word to
// the next layer's feature buffer.
module psum_writeback #(
   parameter int PSUM_W = 20,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 12,
   parameter int LANES  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_num_words,
   input  logic [4:0]        i_shift,
   output logic              o_busy,
   output logic              o_done,
   psum_writeback_if.slave   bus
);

   localparam int DATA_W = 8 * LANES;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   // Layer parameters captured at start
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_num_words;
   logic [4:0]          r_shift;

   // Accumulation / packing state
   logic [ACC_W-1:0]    r_acc;
   logic                r_first;
   logic [LANE_W-1:0]   r_lane_cnt;
   logic [ADDR_W-1:0]   r_word_cnt;
   logic [DATA_W-1:0]   r_pack;

   // BRAM write port registers
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_din;

   // Datapath wires
   logic                w_accept;
   logic                w_finalize;
   logic                w_word_full;
   logic                w_last_word;
   logic [ACC_W-1:0]    w_acc_base;
   logic [ACC_W:0]      w_sum;
   logic [ACC_W-1:0]    w_acc_next;
   logic [ACC_W-1:0]    w_relu;
   logic [ACC_W-1:0]    w_shifted;
   logic [7:0]          w_lane_val;
   logic [DATA_W-1:0]   w_pack_next;

   assign w_accept    = (r_state == RUN) && bus.psum_valid;
   assign w_finalize  = w_accept && bus.psum_last;
   assign w_word_full = w_finalize && (r_lane_cnt == LANE_W'(LANES - 1));
   assign w_last_word = w_word_full && (r_word_cnt == r_num_words - 1'b1);

   // Accumulate with saturation, then ReLU, requant shift and int8 clamp
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_acc_base  = r_first ? '0 : r_acc;
      w_sum       = {w_acc_base[ACC_W-1], w_acc_base}
                  + {{(ACC_W + 1 - PSUM_W){bus.psum_data[PSUM_W-1]}}, bus.psum_data};
      w_acc_next  = w_sum[ACC_W-1:0];
      if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
         // Overflow: clamp to the signed ACC_W extreme on the side of the true sign
         w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                   : {1'b0, {(ACC_W - 1){1'b1}}};
      end
      w_relu      = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
      w_shifted   = w_relu >> r_shift;
      w_lane_val  = (w_shifted > ACC_W'(127)) ? 8'd127 : w_shifted[7:0];
      w_pack_next = r_pack;
      for (int k = 0; k < LANES; k++) begin
         if (r_lane_cnt == LANE_W'(k)) begin
            w_pack_next[8*k +: 8] = w_lane_val;
         end
      end
   end

   // Next-state logic for the layer sequencer
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_next = (i_num_words == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (w_last_word) begin
               w_state_next = FINISH;
            end
         end
         FINISH:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Parameter capture, accumulation, packing and BRAM write generation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base      <= '0;
         r_num_words <= '0;
         r_shift     <= '0;
         r_acc       <= '0;
         r_first     <= 1'b1;
         r_lane_cnt  <= '0;
         r_word_cnt  <= '0;
         r_pack      <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_din       <= '0;
      end else begin
         r_we <= 1'b0;

         if ((r_state == IDLE) && i_start) begin
            r_base      <= i_base_addr;
            r_num_words <= i_num_words;
            r_shift     <= i_shift;
            r_word_cnt  <= '0;
            r_lane_cnt  <= '0;
            r_first     <= 1'b1;
            r_acc       <= '0;
         end

         if (w_accept) begin
            r_acc   <= w_acc_next;
            // The beat after a last beat starts a fresh output sum
            r_first <= bus.psum_last;
            if (w_finalize) begin
               r_pack     <= w_pack_next;
               r_lane_cnt <= w_word_full ? '0 : r_lane_cnt + 1'b1;
            end
            if (w_word_full) begin
               r_we       <= 1'b1;
               r_addr     <= r_base + r_word_cnt;
               r_din      <= w_pack_next;
               r_word_cnt <= r_word_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.psum_ready = (r_state == RUN);
   assign bus.bram_we    = r_we;
   assign bus.bram_addr  = r_addr;
   assign bus.bram_din   = r_din;
   assign o_busy         = (r_state != IDLE);
   assign o_done         = (r_state == FINISH);

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: one task per scenario, inline checks
// against hand-computed packed words, addresses and handshake timing.
module tb_psum_writeback;

   localparam int PSUM_W = 20;
   localparam int ACC_W  = 24;
   localparam int ADDR_W = 12;
   localparam int LANES  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] num_words;
   logic [4:0]        shift;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;
   int wr_count = 0;

   psum_writeback_if #(.PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .LANES(LANES)) bif ();

   psum_writeback #(
      .PSUM_W(PSUM_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .LANES(LANES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_num_words (num_words),
      .i_shift     (shift),
      .o_busy      (busy),
      .o_done      (done),
      .bus         (bif)
   );

   always #5 clk = ~clk;

   // Count BRAM writes, sampled mid-cycle
   always @(negedge clk) begin
      if (bif.bram_we === 1'b1) wr_count++;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, input logic [4:0] s);
      start     = 1'b1;
      base_addr = b;
      num_words = n;
      shift     = s;
      step();
      start     = 1'b0;
   endtask

   // Present one beat and hold it until accepted (bounded)
   task automatic send_beat(input int d, input logic l);
      int waited;
      waited = 0;
      bif.psum_valid = 1'b1;
      bif.psum_data  = PSUM_W'(d);
      bif.psum_last  = l;
      while (bif.psum_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL beat_timeout: psum_ready=%b after %0d cycles, required 1", bif.psum_ready, waited);
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; shift = '0;
      bif.psum_valid = 1'b0; bif.psum_data = '0; bif.psum_last = 1'b0;
      step(); step();
      n_checks++; if (bif.psum_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b required 0", bif.psum_ready); end
      n_checks++; if (bif.bram_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b required 0", bif.bram_we); end
      n_checks++; if (bif.bram_addr !== 12'h000) begin n_errors++; $display("FAIL reset_addr: got %h required 000", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h0) begin n_errors++; $display("FAIL reset_din: got %h required 0", bif.bram_din); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b required 0", done); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_pack();
      int wc0;
      wc0 = wr_count;
      do_start(12'h100, 12'd1, 5'd0);
      n_checks++; if (bif.psum_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready_after_start: got %b required 1", bif.psum_ready); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b required 1", busy); end
      for (int i = 0; i < 8; i++) send_beat(i + 1, 1'b1);
      bif.psum_valid = 1'b0;
      n_checks++; if (bif.bram_we !== 1'b1) begin n_errors++; $display("FAIL basic_we: got %b required 1", bif.bram_we); end
      n_checks++; if (bif.bram_addr !== 12'h100) begin n_errors++; $display("FAIL basic_addr: got %h required 100", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h0807060504030201) begin n_errors++; $display("FAIL basic_din: got %h required 0807060504030201", bif.bram_din); end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b required 1", done); end
      n_checks++; if (bif.psum_ready !== 1'b0) begin n_errors++; $display("FAIL basic_ready_low: got %b required 0", bif.psum_ready); end
      step();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse: got %b required 0", done); end
      n_checks++; if (bif.bram_we !== 1'b0) begin n_errors++; $display("FAIL basic_we_pulse: got %b required 0", bif.bram_we); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_end: got %b required 0", busy); end
      n_checks++; if (bif.bram_din !== 64'h0807060504030201) begin n_errors++; $display("FAIL basic_din_hold: got %h required 0807060504030201", bif.bram_din); end
      n_checks++; if (wr_count - wc0 !== 1) begin n_errors++; $display("FAIL basic_write_count: got %0d required 1", wr_count - wc0); end
   endtask

   task automatic test_channel_accum();
      do_start(12'h010, 12'd1, 5'd2);
      for (int lane = 0; lane < 8; lane++) begin
         send_beat(100, 1'b0);
         send_beat(50, 1'b0);
         send_beat(-10, 1'b1);
      end
      bif.psum_valid = 1'b0;
      n_checks++; if (bif.bram_we !== 1'b1) begin n_errors++; $display("FAIL accum_we: got %b required 1", bif.bram_we); end
      n_checks++; if (bif.bram_addr !== 12'h010) begin n_errors++; $display("FAIL accum_addr: got %h required 010", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h2323232323232323) begin n_errors++; $display("FAIL accum_din: got %h required 2323232323232323", bif.bram_din); end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL accum_done: got %b required 1", done); end
      step();
   endtask

   task automatic test_relu_sat();
      do_start(12'h020, 12'd1, 5'd0);
      send_beat(-500, 1'b1);
      send_beat(0, 1'b1);
      send_beat(127, 1'b1);
      send_beat(128, 1'b1);
      send_beat(100000, 1'b1);
      // 20 x 0x7FFFF exceeds the signed 24-bit range; a wrapped sum would go negative
      for (int i = 0; i < 20; i++) send_beat(32'h7FFFF, (i == 19));
      send_beat(5, 1'b1);
      send_beat(64, 1'b1);
      bif.psum_valid = 1'b0;
      n_checks++; if (bif.bram_we !== 1'b1) begin n_errors++; $display("FAIL relu_we: got %b required 1", bif.bram_we); end
      n_checks++; if (bif.bram_din !== 64'h40057F7F7F7F0000) begin n_errors++; $display("FAIL relu_din: got %h required 40057F7F7F7F0000", bif.bram_din); end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL relu_done: got %b required 1", done); end
      step();
   endtask

   task automatic test_back_to_back();
      int wc0;
      int stalls;
      int we_bad;
      logic [63:0]       exp_din;
      logic [ADDR_W-1:0] exp_addr;
      int w;
      wc0 = wr_count; stalls = 0; we_bad = 0;
      do_start(12'hFFE, 12'd3, 5'd0);
      for (int i = 0; i < 24; i++) begin
         bif.psum_valid = 1'b1;
         bif.psum_data  = PSUM_W'(i + 1);
         bif.psum_last  = 1'b1;
         if (bif.psum_ready !== 1'b1) stalls++;
         step();
         if ((i % 8) == 7) begin
            w = i / 8;
            for (int k = 0; k < 8; k++) exp_din[8*k +: 8] = 8'(8 * w + k + 1);
            exp_addr = (w == 0) ? 12'hFFE : (w == 1) ? 12'hFFF : 12'h000;
            n_checks++; if (bif.bram_we !== 1'b1) begin n_errors++; $display("FAIL b2b_we_w%0d: got %b required 1", w, bif.bram_we); end
            n_checks++; if (bif.bram_addr !== exp_addr) begin n_errors++; $display("FAIL b2b_addr_w%0d: got %h required %h", w, bif.bram_addr, exp_addr); end
            n_checks++; if (bif.bram_din !== exp_din) begin n_errors++; $display("FAIL b2b_din_w%0d: got %h required %h", w, bif.bram_din, exp_din); end
            n_checks++; if (done !== (w == 2)) begin n_errors++; $display("FAIL b2b_done_w%0d: got %b required %b", w, done, (w == 2)); end
         end else if (bif.bram_we !== 1'b0) begin
            we_bad++;
         end
      end
      bif.psum_valid = 1'b0;
      n_checks++; if (stalls !== 0) begin n_errors++; $display("FAIL b2b_stalls: got %0d required 0", stalls); end
      n_checks++; if (we_bad !== 0) begin n_errors++; $display("FAIL b2b_stray_we: got %0d required 0", we_bad); end
      n_checks++; if (bif.psum_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_low: got %b required 0", bif.psum_ready); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_end: got %b required 0", busy); end
      n_checks++; if (wr_count - wc0 !== 3) begin n_errors++; $display("FAIL b2b_write_count: got %0d required 3", wr_count - wc0); end
   endtask

   task automatic test_zero_words();
      int wc0;
      wc0 = wr_count;
      do_start(12'h123, 12'd0, 5'd0);
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL zero_done: got %b required 1", done); end
      n_checks++; if (bif.bram_we !== 1'b0) begin n_errors++; $display("FAIL zero_we: got %b required 0", bif.bram_we); end
      n_checks++; if (bif.psum_ready !== 1'b0) begin n_errors++; $display("FAIL zero_ready: got %b required 0", bif.psum_ready); end
      step();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done_pulse: got %b required 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy: got %b required 0", busy); end
      n_checks++; if (wr_count - wc0 !== 0) begin n_errors++; $display("FAIL zero_write_count: got %0d required 0", wr_count - wc0); end
   endtask

   task automatic test_start_in_run();
      do_start(12'h200, 12'd1, 5'd0);
      for (int i = 0; i < 3; i++) send_beat(10 + i, 1'b1);
      bif.psum_valid = 1'b0;
      // A second start with different parameters must be ignored
      do_start(12'h300, 12'd5, 5'd3);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rerun_busy: got %b required 1", busy); end
      for (int i = 3; i < 8; i++) send_beat(10 + i, 1'b1);
      bif.psum_valid = 1'b0;
      n_checks++; if (bif.bram_addr !== 12'h200) begin n_errors++; $display("FAIL rerun_addr: got %h required 200", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h11100F0E0D0C0B0A) begin n_errors++; $display("FAIL rerun_din: got %h required 11100F0E0D0C0B0A", bif.bram_din); end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rerun_done: got %b required 1", done); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rerun_busy_end: got %b required 0", busy); end
   endtask

   task automatic test_reset_mid();
      int wc0;
      wc0 = wr_count;
      do_start(12'h050, 12'd1, 5'd0);
      for (int i = 0; i < 5; i++) send_beat(9, 1'b1);
      send_beat(50, 1'b0);
      bif.psum_valid = 1'b0;
      rst = 1'b1;
      step();
      n_checks++; if (bif.psum_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready: got %b required 0", bif.psum_ready); end
      n_checks++; if (bif.bram_we !== 1'b0) begin n_errors++; $display("FAIL rstmid_we: got %b required 0", bif.bram_we); end
      n_checks++; if (bif.bram_addr !== 12'h000) begin n_errors++; $display("FAIL rstmid_addr: got %h required 000", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h0) begin n_errors++; $display("FAIL rstmid_din: got %h required 0", bif.bram_din); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b required 0", done); end
      rst = 1'b0;
      step();
      n_checks++; if (wr_count - wc0 !== 0) begin n_errors++; $display("FAIL rstmid_write_count: got %0d required 0", wr_count - wc0); end
      do_start(12'h060, 12'd1, 5'd0);
      for (int i = 0; i < 8; i++) send_beat(32'h21 + i, 1'b1);
      bif.psum_valid = 1'b0;
      n_checks++; if (bif.bram_addr !== 12'h060) begin n_errors++; $display("FAIL rstmid_new_addr: got %h required 060", bif.bram_addr); end
      n_checks++; if (bif.bram_din !== 64'h2827262524232221) begin n_errors++; $display("FAIL rstmid_new_din: got %h required 2827262524232221", bif.bram_din); end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rstmid_new_done: got %b required 1", done); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_channel_accum();
      test_relu_sat();
      test_back_to_back();
      test_zero_words();
      test_start_in_run();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
